recog_calc: RTL and testbench
=============================

Name: recog_calc

Overview:
- Consumer side of the digit/operator recogniser interface.
- Takes the per-frame feature codes (num_1, num_2, sym) and debounces them across frames.
- Decodes the codes into two digits and an operator, then computes the result sequentially.
- Presents the result as sign + 2-digit BCD (+ optional remainder) with a one-cycle valid pulse for the display/overlay logic.

Parameters:
- STABLE_CNT, 3, number of consecutive identical code strobes required before a calculation starts (1..15).

Ports:
- clk  input  1  pixel clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- code_stb  input  1  one-cycle pulse: num_1/num_2/sym updated (top generates it one cycle after recogniser latch point).
- num_1  input  8  feature code of left digit {y1cnt[1:0],y2cnt[1:0],xcnt[1:0],a,c}.
- num_2  input  8  feature code of right digit, same format.
- sym  input  4  operator feature code.
- busy  output  1  high from acceptance until res_valid cycle inclusive.
- res_valid  output  1  one-cycle pulse, result/err fields valid.
- res_neg  output  1  result negative (subtraction only).
- res_bcd  output  8  result magnitude, {tens,units} BCD, 00..81.
- res_rem  output  4  division remainder (optional feature).
- err  output  2  0 ok, 1 bad digit code, 2 bad operator code, 3 divide by zero.

Behaviour:
- Reset: all outputs 0, FSM IDLE, stability counter 0, stored codes 0.
- Debounce, in IDLE only:
  - On code_stb, compare {num_1,num_2,sym} with stored copy.
  - Equal: counter+1, saturating at STABLE_CNT. Different: store new codes, counter=1.
  - When the counter reaches STABLE_CNT on a strobe, that strobe is accepted: cycle 0, busy=1, counter cleared.
  - code_stb while busy is ignored and does not count.
- Digit decode (package LUT, all other codes invalid): 0=AB, 1=54, 2=5E, 3=5F, 4=97, 5=5D, 6=6D, 7=57, 8=AF, 9=9F (hex).
- Operator decode: 5='+', 0='-', A='*', 4='/'; all other codes invalid.
- FSM: IDLE -> DECODE -> CALC -> BCD -> DONE -> IDLE.
- DECODE (cycle 1):
  - Look up digits and operator.
  - Error priority: bad num_1/num_2 -> err=1; else bad sym -> err=2; else '/' with divisor 0 -> err=3.
  - On any error: go to DONE.
- CALC (cycles 2-5, always 4 cycles):
  - '+': A+B.
  - '-': A-B; if A<B then res_neg=1 and magnitude B-A.
  - '*': A*B.
  - '/': 4-iteration restoring divide, one quotient bit per cycle, giving quotient and remainder.
  - Binary result is 7 bits, max 81.
- BCD (cycles 6-12): 7-iteration shift-add-3 (double dabble) into 8-bit BCD.
- DONE (cycle 13):
  - Output registers load; res_valid=1 for exactly one cycle; busy drops the next cycle.
  - Error path reaches DONE at cycle 2 with res_bcd=00, res_neg=0, res_rem=0.
- Outputs hold until the next DONE.
- Reset mid-operation: immediate IDLE, no res_valid, outputs cleared.

Optional Feature:
- RECOG_CALC_DIV_REM_EN defined: res_rem carries the division remainder; it is 0 for non-divide ops.
- Not defined: res_rem is tied to 0, the remainder register is removed, and division still yields the quotient in 4 cycles.

Decomposition:
- Package recog_calc_pkg holds:
  - op_t enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV).
  - err_t enum.
  - DIGIT_CODE[0:9] constant array.
  - Operator code constants.
  - State enum.
- One sub-module is natural: bin2bcd_seq. It is a 7-bit iterative double-dabble with start/done, reusable by the display path.

Test Plan:
- num_1=5F, num_2=6D, sym=A, 3 identical strobes -> res_valid 13 cycles after 3rd strobe, res_bcd=18, res_neg=0, err=0.
- num_1=5E, num_2=57, sym=0, 3 strobes -> res_neg=1, res_bcd=05, err=0.
- num_1=9F, num_2=5E, sym=4 -> res_bcd=04, res_rem=1 with macro, res_rem=0 without.
- num_1=AF, num_2=AB, sym=4 -> res_valid 2 cycles after acceptance, err=3, res_bcd=00; num_1=FF -> err=1; sym=F with valid digits -> err=2.
- Alternating codes on strobes 1-2, then 3 identical -> exactly one res_valid; strobes during busy -> ignored, no second result until 3 new stable strobes.
- rst asserted at cycle 8 of a '*' 9x9 -> no res_valid, all outputs 0; after release, the next 3 stable strobes give res_bcd=81.

Source files
------------

// File: rtl/recog_calc_pkg.sv
// Shared types and code tables for the recogniser calculator: operator/error/state
// enums, digit feature-code LUT and operator code constants.
package recog_calc_pkg;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_DIGIT = 2'd1,
    ERR_OP    = 2'd2,
    ERR_DIV0  = 2'd3
  } err_t;

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_CALC, S_BCD, S_DONE} state_t;

  localparam logic [7:0] DIGIT_CODE [0:9] = '{
    8'hAB, 8'h54, 8'h5E, 8'h5F, 8'h97, 8'h5D, 8'h6D, 8'h57, 8'hAF, 8'h9F
  };

  localparam logic [3:0] SYM_ADD = 4'h5;
  localparam logic [3:0] SYM_SUB = 4'h0;
  localparam logic [3:0] SYM_MUL = 4'hA;
  localparam logic [3:0] SYM_DIV = 4'h4;

  localparam int BCD_ITERS = 7;

  // Returns {valid, digit value}; unknown codes give valid=0.
  function automatic logic [4:0] digit_lookup(input logic [7:0] code);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      if (code == DIGIT_CODE[i]) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // Returns {valid, op_t}.
  function automatic logic [2:0] op_lookup(input logic [3:0] code);
    logic [2:0] r;
    case (code)
      SYM_ADD: r = {1'b1, OP_ADD};
      SYM_SUB: r = {1'b1, OP_SUB};
      SYM_MUL: r = {1'b1, OP_MUL};
      SYM_DIV: r = {1'b1, OP_DIV};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/recog_calc_bin2bcd_seq.sv
// Iterative 7-bit binary to 2-digit BCD converter (double dabble) with start/done.
// The start cycle performs the first shift, so done pulses six cycles after start.
module bin2bcd_seq
  import recog_calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] bin,
  output logic       done,
  output logic [7:0] bcd
);

  logic [5:0] shift_q;
  logic [2:0] iter_cnt;
  logic       active;
  logic [7:0] adj;

  function automatic logic [7:0] dd_adjust(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (r[3:0] >= 4'd5) r[3:0] = r[3:0] + 4'd3;
    if (r[7:4] >= 4'd5) r[7:4] = r[7:4] + 4'd3;
    return r;
  endfunction

  assign adj = dd_adjust(bcd);

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      iter_cnt <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        iter_cnt <= 3'(BCD_ITERS - 1);
      end else if (active) begin
        iter_cnt <= iter_cnt - 3'd1;
        if (iter_cnt == 3'd1) begin
          active <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

  // First iteration needs no adjust since the BCD accumulator starts at zero.
  always_ff @(posedge clk) begin
    if (start) begin
      bcd     <= {7'b0, bin[6]};
      shift_q <= bin[5:0];
    end else if (active) begin
      bcd     <= (adj << 1) | {7'b0, shift_q[5]};
      shift_q <= {shift_q[4:0], 1'b0};
    end
  end

endmodule

// File: rtl/recog_calc.sv
// Recogniser calculator: debounces feature-code strobes, decodes two digits and an
// operator, computes sequentially and reports sign + BCD. Remainder: RECOG_CALC_DIV_REM_EN.
module recog_calc
  import recog_calc_pkg::*;
#(
  parameter int STABLE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_stb,
  input  logic [7:0] num_1,
  input  logic [7:0] num_2,
  input  logic [3:0] sym,
  output logic       busy,
  output logic       res_valid,
  output logic       res_neg,
  output logic [7:0] res_bcd,
  output logic [3:0] res_rem,
  output logic [1:0] err
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CNT);

  state_t      state, state_next;
  logic [19:0] code_in, code_q;
  logic [3:0]  stab_cnt, cnt_after;
  logic        code_match, accept;
  logic [1:0]  cyc;
  logic [3:0]  a_q, b_q, quo_q, rem_q;
  op_t         op_q;
  logic        neg_q;
  logic [4:0]  dig_a, dig_b;
  logic [2:0]  op_dec;
  err_t        dec_err;
  logic [4:0]  trial;
  logic [3:0]  trial_sub, rem_next;
  logic        qbit;
  logic [6:0]  calc_val;
  logic        bcd_start, bcd_done;
  logic [7:0]  bcd_val;

  assign code_in    = {num_1, num_2, sym};
  assign code_match = (code_in == code_q);
  assign cnt_after  = !code_match ? 4'd1 :
                      (stab_cnt >= STABLE_N) ? STABLE_N : stab_cnt + 4'd1;
  assign accept     = (state == S_IDLE) && code_stb && (cnt_after == STABLE_N);
  assign busy       = (state != S_IDLE);
  assign bcd_start  = (state == S_CALC) && (cyc == 2'd3);

  always_comb begin
    dig_a   = digit_lookup(code_q[19:12]);
    dig_b   = digit_lookup(code_q[11:4]);
    op_dec  = op_lookup(code_q[3:0]);
    dec_err = ERR_NONE;
    if (!dig_a[4] || !dig_b[4])
      dec_err = ERR_DIGIT;
    else if (!op_dec[2])
      dec_err = ERR_OP;
    else if ((op_t'(op_dec[1:0]) == OP_DIV) && (dig_b[3:0] == 4'd0))
      dec_err = ERR_DIV0;
  end

  // Restoring divide step: one dividend bit enters the partial remainder per cycle.
  always_comb begin
    trial     = {rem_q, quo_q[3]};
    trial_sub = trial[3:0] - b_q;
    qbit      = (trial >= {1'b0, b_q});
    rem_next  = qbit ? trial_sub : trial[3:0];
  end

  // For division the final quotient bit is folded in combinationally on the last CALC cycle.
  always_comb begin
    calc_val = '0;
    case (op_q)
      OP_ADD:  calc_val = 7'(a_q) + 7'(b_q);
      OP_SUB:  calc_val = (a_q >= b_q) ? 7'(a_q) - 7'(b_q) : 7'(b_q) - 7'(a_q);
      OP_MUL:  calc_val = 7'(a_q) * 7'(b_q);
      OP_DIV:  calc_val = {3'b000, quo_q[2:0], qbit};
      default: calc_val = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_DECODE;
      S_DECODE: state_next = (dec_err != ERR_NONE) ? S_DONE : S_CALC;
      S_CALC:   if (cyc == 2'd3) state_next = S_BCD;
      S_BCD:    if (bcd_done) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt  <= '0;
      code_q    <= '0;
      cyc       <= '0;
      res_valid <= 1'b0;
      res_neg   <= 1'b0;
      res_bcd   <= '0;
      err       <= '0;
    end else begin
      res_valid <= 1'b0;
      cyc       <= (state == S_CALC) ? cyc + 2'd1 : 2'd0;
      if ((state == S_IDLE) && code_stb) begin
        stab_cnt <= accept ? 4'd0 : cnt_after;
        if (!code_match) code_q <= code_in;
      end
      if ((state == S_DECODE) && (dec_err != ERR_NONE)) begin
        res_valid <= 1'b1;
        err       <= dec_err;
        res_bcd   <= '0;
        res_neg   <= 1'b0;
      end else if ((state == S_BCD) && bcd_done) begin
        res_valid <= 1'b1;
        err       <= ERR_NONE;
        res_bcd   <= bcd_val;
        res_neg   <= neg_q;
      end
    end
  end

  // Operand registers carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (state == S_DECODE) begin
      a_q   <= dig_a[3:0];
      b_q   <= dig_b[3:0];
      op_q  <= op_t'(op_dec[1:0]);
      neg_q <= (op_t'(op_dec[1:0]) == OP_SUB) && (dig_a[3:0] < dig_b[3:0]);
      quo_q <= dig_a[3:0];
      rem_q <= '0;
    end else if ((state == S_CALC) && (op_q == OP_DIV)) begin
      quo_q <= {quo_q[2:0], qbit};
      rem_q <= rem_next;
    end
  end

`ifdef RECOG_CALC_DIV_REM_EN
  always_ff @(posedge clk) begin
    if (rst)
      res_rem <= '0;
    else if ((state == S_DECODE) && (dec_err != ERR_NONE))
      res_rem <= '0;
    else if ((state == S_BCD) && bcd_done)
      res_rem <= (op_q == OP_DIV) ? rem_q : 4'd0;
  end
`else
  assign res_rem = 4'd0;
`endif

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (calc_val),
    .done  (bcd_done),
    .bcd   (bcd_val)
  );

endmodule

// File: tb/tb_recog_calc.sv
// Directed bench for recog_calc: spec-level model plus per-cycle output compare.
module tb_recog_calc;

  localparam int STABLE = 3;

  logic       clk, rst, code_stb;
  logic [7:0] num_1, num_2;
  logic [3:0] sym;
  logic       busy, res_valid, res_neg;
  logic [7:0] res_bcd;
  logic [3:0] res_rem;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  bit chk_en = 0;

  // model state
  int          edge_n;
  bit          m_busy;
  int          m_valid_edge, m_end_edge, m_cnt;
  logic [19:0] m_codes;
  logic        exp_valid, exp_neg;
  logic [7:0]  exp_bcd, p_bcd;
  logic [3:0]  exp_rem, p_rem;
  logic [1:0]  exp_err, p_err;
  logic        p_neg;

  recog_calc #(.STABLE_CNT(STABLE)) dut (
    .clk(clk), .rst(rst), .code_stb(code_stb), .num_1(num_1), .num_2(num_2),
    .sym(sym), .busy(busy), .res_valid(res_valid), .res_neg(res_neg),
    .res_bcd(res_bcd), .res_rem(res_rem), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int digit_val(input logic [7:0] c);
    case (c)
      8'hAB: return 0;  8'h54: return 1;  8'h5E: return 2;  8'h5F: return 3;
      8'h97: return 4;  8'h5D: return 5;  8'h6D: return 6;  8'h57: return 7;
      8'hAF: return 8;  8'h9F: return 9;
      default: return -1;
    endcase
  endfunction

  task automatic model_calc(input logic [19:0] c, output logic [1:0] e, output logic n,
                            output logic [7:0] b, output logic [3:0] r);
    int a, d, v;
    e = 0; n = 0; b = 0; r = 0; v = 0;
    a = digit_val(c[19:12]);
    d = digit_val(c[11:4]);
    if (a < 0 || d < 0) e = 1;
    else begin
      case (c[3:0])
        4'h5: v = a + d;
        4'h0: begin v = a - d; if (v < 0) begin n = 1; v = -v; end end
        4'hA: v = a * d;
        4'h4: begin
          if (d == 0) e = 3;
          else begin
            v = a / d;
`ifdef RECOG_CALC_DIV_REM_EN
            r = 4'(a % d);
`endif
          end
        end
        default: e = 2;
      endcase
    end
    if (e == 0) b = 8'(((v / 10) << 4) | (v % 10));
  endtask

  // Spec-level model: debounce, fixed latencies, held outputs.
  initial begin
    edge_n = 0; m_busy = 0; m_cnt = 0; m_codes = '0;
    m_valid_edge = 0; m_end_edge = 0;
    exp_valid = 0; exp_neg = 0; exp_bcd = 0; exp_rem = 0; exp_err = 0;
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        m_busy = 0; m_cnt = 0; m_codes = '0;
        exp_valid = 0; exp_neg = 0; exp_bcd = 0; exp_rem = 0; exp_err = 0;
      end else begin
        exp_valid = 0;
        if (m_busy && edge_n == m_valid_edge) begin
          exp_valid = 1; exp_bcd = p_bcd; exp_neg = p_neg; exp_rem = p_rem; exp_err = p_err;
        end
        if (m_busy && edge_n == m_end_edge) m_busy = 0;
        else if (!m_busy && code_stb) begin
          if ({num_1, num_2, sym} == m_codes) begin
            if (m_cnt < STABLE) m_cnt++;
          end else begin
            m_codes = {num_1, num_2, sym};
            m_cnt = 1;
          end
          if (m_cnt == STABLE) begin
            m_cnt = 0;
            model_calc(m_codes, p_err, p_neg, p_bcd, p_rem);
            m_busy = 1;
            m_valid_edge = edge_n + ((p_err != 0) ? 1 : 12);
            m_end_edge   = edge_n + ((p_err != 0) ? 2 : 13);
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("valid", res_valid, exp_valid);
      chk("busy",  busy,      m_busy);
      chk("bcd",   res_bcd,   exp_bcd);
      chk("neg",   res_neg,   exp_neg);
      chk("rem",   res_rem,   exp_rem);
      chk("err",   err,       exp_err);
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (res_valid) vcount++;
  end

  task automatic strobe(input logic [7:0] n1, input logic [7:0] n2, input logic [3:0] s);
    @(negedge clk);
    num_1 = n1; num_2 = n2; sym = s; code_stb = 1;
    @(negedge clk);
    code_stb = 0;
  endtask

  // Issues one strobe and counts cycles until res_valid is seen (bounded).
  task automatic strobe_wait(input logic [7:0] n1, input logic [7:0] n2, input logic [3:0] s,
                             output int lat);
    @(negedge clk);
    num_1 = n1; num_2 = n2; sym = s; code_stb = 1;
    lat = 0;
    do begin
      @(negedge clk);
      code_stb = 0;
      lat++;
    end while (!res_valid && lat < 40);
  endtask

  task automatic run3(input logic [7:0] n1, input logic [7:0] n2, input logic [3:0] s,
                      output int lat);
    strobe(n1, n2, s);
    strobe(n1, n2, s);
    strobe_wait(n1, n2, s, lat);
  endtask

  initial begin
    int lat, v0;
    rst = 1; code_stb = 0; num_1 = 0; num_2 = 0; sym = 0;
    repeat (3) @(negedge clk);
    chk("reset_valid", res_valid, 0);
    chk("reset_busy",  busy,      0);
    chk("reset_bcd",   res_bcd,   0);
    chk("reset_err",   err,       0);
    rst = 0;
    chk_en = 1;
    repeat (2) @(negedge clk);

    // 3 * 6 = 18
    run3(8'h5F, 8'h6D, 4'hA, lat);
    chk("mul_latency", lat, 13);
    chk("mul_bcd", res_bcd, 8'h18);
    chk("mul_neg", res_neg, 0);
    chk("mul_err", err, 0);
    chk("model_mul", exp_bcd, 8'h18);
    repeat (2) @(negedge clk);

    // 2 - 7 = -5
    run3(8'h5E, 8'h57, 4'h0, lat);
    chk("sub_neg", res_neg, 1);
    chk("sub_bcd", res_bcd, 8'h05);
    chk("model_sub", {exp_neg, exp_bcd}, 9'h105);
    repeat (2) @(negedge clk);

    // 9 / 2 = 4 r 1
    run3(8'h9F, 8'h5E, 4'h4, lat);
    chk("div_bcd", res_bcd, 8'h04);
`ifdef RECOG_CALC_DIV_REM_EN
    chk("div_rem", res_rem, 1);
`else
    chk("div_rem", res_rem, 0);
`endif
    repeat (2) @(negedge clk);

    // 8 / 0
    run3(8'hAF, 8'hAB, 4'h4, lat);
    chk("div0_latency", lat, 2);
    chk("div0_err", err, 3);
    chk("div0_bcd", res_bcd, 0);
    repeat (2) @(negedge clk);

    run3(8'hFF, 8'h5E, 4'h5, lat);
    chk("bad_digit_err", err, 1);
    repeat (2) @(negedge clk);

    run3(8'h5F, 8'h6D, 4'hF, lat);
    chk("bad_op_err", err, 2);
    chk("model_bad_op", exp_err, 2);
    repeat (2) @(negedge clk);

    // alternating codes, then 7 * 5 = 35 stable
    v0 = vcount;
    strobe(8'h5D, 8'h5D, 4'h5);
    strobe(8'h54, 8'h54, 4'h5);
    strobe(8'h57, 8'h5D, 4'hA);
    strobe(8'h57, 8'h5D, 4'hA);
    strobe_wait(8'h57, 8'h5D, 4'hA, lat);
    chk("alt_one_result", vcount - v0, 1);
    chk("alt_bcd", res_bcd, 8'h35);
    repeat (3) @(negedge clk);

    // strobes while busy must not count
    v0 = vcount;
    strobe(8'h57, 8'h5D, 4'h5);
    strobe(8'h57, 8'h5D, 4'h5);
    strobe(8'h57, 8'h5D, 4'h5);
    for (int i = 0; i < 5; i++) strobe(8'h57, 8'h5D, 4'h5);
    repeat (6) @(negedge clk);
    chk("busy_ignore_count", vcount - v0, 1);
    chk("add_bcd", res_bcd, 8'h12);
    strobe(8'h57, 8'h5D, 4'h5);
    strobe(8'h57, 8'h5D, 4'h5);
    repeat (4) @(negedge clk);
    chk("two_strobes_no_result", vcount - v0, 1);
    strobe_wait(8'h57, 8'h5D, 4'h5, lat);
    chk("third_strobe_result", vcount - v0, 2);
    chk("third_strobe_latency", lat, 13);
    repeat (3) @(negedge clk);

    // reset in the middle of 9 * 9
    v0 = vcount;
    strobe(8'h9F, 8'h9F, 4'hA);
    strobe(8'h9F, 8'h9F, 4'hA);
    @(negedge clk);
    code_stb = 1;
    @(negedge clk);
    code_stb = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_bcd", res_bcd, 0);
    chk("midrst_err", err, 0);
    @(negedge clk);
    rst = 0;
    repeat (15) @(negedge clk);
    chk("midrst_no_valid", vcount - v0, 0);
    run3(8'h9F, 8'h9F, 4'hA, lat);
    chk("after_rst_bcd", res_bcd, 8'h81);
    chk("after_rst_latency", lat, 13);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
